// File: rtl/otter_lsu_pkg.sv
// Shared types and helpers for the OTTER load/store unit.
package otter_lsu_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_ISSUE0,
      ST_RD_WAIT0,
      ST_RD_ISSUE1,
      ST_RD_WAIT1,
      ST_WR_BEAT,
      ST_DONE
   } lsu_state_t;

   localparam logic [1:0]  SZ_BYTE = 2'd0;
   localparam logic [1:0]  SZ_HALF = 2'd1;
   localparam logic [1:0]  SZ_WORD = 2'd2;
   localparam logic [31:0] IO_BASE_DEFAULT = 32'h1100_0000;

   // Only the low address bits decide whether an access crosses a word.
   function automatic logic is_misaligned(input logic [1:0] addr, input logic [1:0] size);
      return ((size == SZ_HALF) && (addr == 2'd3)) ||
             ((size == SZ_WORD) && (addr != 2'd0));
   endfunction

endpackage

// File: rtl/otter_lsu_rdalign.sv
// Merges the two captured words, shifts by byte offset, and zero/sign-extends the load.
module otter_lsu_rdalign
   import otter_lsu_pkg::*;
(
   input  logic [31:0] w0_i,
   input  logic [31:0] w1_i,
   input  logic [1:0]  off_i,
   input  logic [1:0]  size_i,
   input  logic        uns_i,
   output logic [31:0] rdata_o
);

   logic [31:0] low_c;

   assign low_c = 32'({w1_i, w0_i} >> {off_i, 3'b000});

   always_comb begin
      rdata_o = low_c;
      case (size_i)
         SZ_BYTE: rdata_o = uns_i ? {24'd0, low_c[7:0]}  : {{24{low_c[7]}}, low_c[7:0]};
         SZ_HALF: rdata_o = uns_i ? {16'd0, low_c[15:0]} : {{16{low_c[15]}}, low_c[15:0]};
         default: rdata_o = low_c;
      endcase
   end

endmodule

// File: rtl/otter_lsu.sv
// Load/store unit driving OTTER memory port 2; splits word-crossing accesses into legal beats.
// Splitting is built only when OTTER_LSU_MISALIGN_SPLIT_EN is defined; otherwise misaligned requests error.
module otter_lsu
   import otter_lsu_pkg::*;
#(
   parameter logic [31:0] IO_BASE = IO_BASE_DEFAULT
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        LSU_REQ,
   output logic        LSU_READY,
   input  logic        LSU_WE,
   input  logic [31:0] LSU_ADDR,
   input  logic [31:0] LSU_WDATA,
   input  logic [1:0]  LSU_SIZE,
   input  logic        LSU_SIGN,
   output logic [31:0] LSU_RDATA,
   output logic        LSU_DONE,
   output logic        LSU_ERR,
   output logic [31:0] MEM_ADDR2,
   output logic [31:0] MEM_DIN2,
   output logic        MEM_WRITE2,
   output logic        MEM_READ2,
   output logic [1:0]  MEM_SIZE,
   output logic        MEM_SIGN,
   input  logic [31:0] MEM_DOUT2
);

   lsu_state_t  state_q;
   logic [31:0] addr_q, wdata_q, w0_q, rdata_q;
   logic [1:0]  size_q;
   logic        sign_q, mmio_q, err_q;
   logic [31:0] w0_c, w1_c, align_c;
   logic [1:0]  off_c, asize_c;
   logic        req_mmio_c, req_mis_c, req_err_c;
`ifdef OTTER_LSU_MISALIGN_SPLIT_EN
   logic [31:0] w1_q;
   logic [1:0]  beat_q, last_beat_c;
   logic        mis_q;
`endif

   assign req_mmio_c = (LSU_ADDR >= IO_BASE);
   assign req_mis_c  = !req_mmio_c && is_misaligned(LSU_ADDR[1:0], LSU_SIZE);
`ifdef OTTER_LSU_MISALIGN_SPLIT_EN
   assign req_err_c   = (LSU_SIZE == 2'd3);
   assign last_beat_c = (size_q == SZ_HALF) ? 2'd1 : 2'd3;
   assign w1_c        = (state_q == ST_RD_WAIT1) ? MEM_DOUT2 : w1_q;
`else
   assign req_err_c = (LSU_SIZE == 2'd3) || req_mis_c;
   assign w1_c      = 32'd0;
`endif

   // The word returning this cycle feeds the aligner directly so the result registers on entry to DONE.
   assign w0_c    = (state_q == ST_RD_WAIT0) ? MEM_DOUT2 : w0_q;
   assign off_c   = mmio_q ? 2'd0 : addr_q[1:0];
   assign asize_c = mmio_q ? SZ_WORD : size_q;

   otter_lsu_rdalign u_rdalign (
      .w0_i    (w0_c),
      .w1_i    (w1_c),
      .off_i   (off_c),
      .size_i  (asize_c),
      .uns_i   (sign_q),
      .rdata_o (align_c)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= ST_IDLE;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         w0_q    <= 32'd0;
         rdata_q <= 32'd0;
         size_q  <= SZ_BYTE;
         sign_q  <= 1'b0;
         mmio_q  <= 1'b0;
         err_q   <= 1'b0;
`ifdef OTTER_LSU_MISALIGN_SPLIT_EN
         w1_q    <= 32'd0;
         beat_q  <= 2'd0;
         mis_q   <= 1'b0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: if (LSU_REQ) begin
               addr_q  <= LSU_ADDR;
               wdata_q <= LSU_WDATA;
               size_q  <= LSU_SIZE;
               sign_q  <= LSU_SIGN;
               mmio_q  <= req_mmio_c;
               err_q   <= req_err_c;
`ifdef OTTER_LSU_MISALIGN_SPLIT_EN
               mis_q   <= req_mis_c;
               beat_q  <= 2'd0;
`endif
               if (req_err_c) begin
                  rdata_q <= 32'd0;
                  state_q <= ST_DONE;
               end else if (LSU_WE) begin
                  state_q <= ST_WR_BEAT;
               end else begin
                  state_q <= ST_RD_ISSUE0;
               end
            end
            ST_RD_ISSUE0: state_q <= ST_RD_WAIT0;
            ST_RD_WAIT0: begin
               w0_q <= MEM_DOUT2;
`ifdef OTTER_LSU_MISALIGN_SPLIT_EN
               if (mis_q) state_q <= ST_RD_ISSUE1;
               else begin
`else
               begin
`endif
                  rdata_q <= align_c;
                  state_q <= ST_DONE;
               end
            end
`ifdef OTTER_LSU_MISALIGN_SPLIT_EN
            ST_RD_ISSUE1: state_q <= ST_RD_WAIT1;
            ST_RD_WAIT1: begin
               w1_q    <= MEM_DOUT2;
               rdata_q <= align_c;
               state_q <= ST_DONE;
            end
`endif
            ST_WR_BEAT: begin
               rdata_q <= 32'd0;
`ifdef OTTER_LSU_MISALIGN_SPLIT_EN
               if (mis_q && (beat_q != last_beat_c)) beat_q <= beat_q + 2'd1;
               else state_q <= ST_DONE;
`else
               state_q <= ST_DONE;
`endif
            end
            ST_DONE: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Memory port is a pure decode of state and latched request fields.
   always_comb begin
      MEM_ADDR2  = 32'd0;
      MEM_DIN2   = 32'd0;
      MEM_WRITE2 = 1'b0;
      MEM_READ2  = 1'b0;
      MEM_SIZE   = SZ_BYTE;
      case (state_q)
         ST_RD_ISSUE0: begin
            MEM_READ2 = 1'b1;
            MEM_ADDR2 = mmio_q ? addr_q : {addr_q[31:2], 2'b00};
            MEM_SIZE  = SZ_WORD;
         end
`ifdef OTTER_LSU_MISALIGN_SPLIT_EN
         ST_RD_ISSUE1: begin
            MEM_READ2 = 1'b1;
            MEM_ADDR2 = {addr_q[31:2], 2'b00} + 32'd4;
            MEM_SIZE  = SZ_WORD;
         end
`endif
         ST_WR_BEAT: begin
            MEM_WRITE2 = 1'b1;
            MEM_ADDR2  = addr_q;
            MEM_SIZE   = size_q;
            MEM_DIN2   = wdata_q;
`ifdef OTTER_LSU_MISALIGN_SPLIT_EN
            if (mis_q) begin
               MEM_ADDR2 = addr_q + 32'(beat_q);
               MEM_SIZE  = SZ_BYTE;
               MEM_DIN2  = {24'd0, wdata_q[{beat_q, 3'b000} +: 8]};
            end
`endif
         end
         default: ;
      endcase
   end

   assign MEM_SIGN  = 1'b0;
   assign LSU_READY = (state_q == ST_IDLE);
   assign LSU_DONE  = (state_q == ST_DONE);
   assign LSU_ERR   = (state_q == ST_DONE) && err_q;
   assign LSU_RDATA = rdata_q;

endmodule

// File: doc/otter_lsu.md
Name: otter_lsu

Overview:
- Load/store unit on the CPU side of the data port (port 2) of the OTTER byte-addressable memory; it is the initiator that drives that port.
- Accepts one load or store from the MEM/WB pipeline stage and drives MEM_ADDR2, MEM_DIN2, MEM_WRITE2, MEM_READ2, MEM_SIZE and MEM_SIGN.
- Splits accesses that cross a word boundary into legal beats, because the memory does not support them.
- Returns aligned, sign/zero-extended load data with a one-cycle done pulse.

Parameters:
- IO_BASE, 32'h11000000: addresses >= IO_BASE are MMIO. They are never split and never flagged misaligned.

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous, active-high reset
- LSU_REQ  in  1  request strobe; sampled only when LSU_READY=1
- LSU_READY  out  1  high only in IDLE
- LSU_WE  in  1  1=store, 0=load
- LSU_ADDR  in  32  byte address
- LSU_WDATA  in  32  store data, right-justified
- LSU_SIZE  in  2  0=byte, 1=half, 2=word, 3=illegal
- LSU_SIGN  in  1  1=unsigned load (func3[2] convention)
- LSU_RDATA  out  32  load result; valid while LSU_DONE=1
- LSU_DONE  out  1  one-cycle completion pulse
- LSU_ERR  out  1  qualifies LSU_DONE: illegal size, or misaligned access when split is disabled
- MEM_ADDR2  out  32  data-port address
- MEM_DIN2  out  32  data-port write data
- MEM_WRITE2  out  1  write strobe
- MEM_READ2  out  1  read strobe
- MEM_SIZE  out  2  beat size
- MEM_SIGN  out  1  beat sign; always 0
- MEM_DOUT2  in  32  read data; valid the cycle after a READ2 beat

Behaviour:
- Reset: state=IDLE. LSU_READY=1. LSU_DONE=0, LSU_ERR=0, LSU_RDATA=0. All MEM_* outputs=0.
- Reset mid-operation aborts immediately. No further strobes are issued, and a partially written misaligned store is left as-is.
- Request fields are latched on the accepting edge. LSU inputs are ignored at all other times.
- All MEM_* outputs are decoded from registered state/latched fields only. They are zero outside the ISSUE/WR states.
- States:
  - IDLE
  - RD_ISSUE0, RD_WAIT0
  - RD_ISSUE1, RD_WAIT1
  - WR_BEAT
  - DONE
- Misaligned: size=1 with ADDR[1:0]=3, or size=2 with ADDR[1:0]!=0, and ADDR < IO_BASE.
- Illegal size (3): IDLE -> DONE with LSU_ERR=1 and no memory beat.
- Aligned load:
  - RD_ISSUE0 drives MEM_READ2=1, MEM_ADDR2={ADDR[31:2],2'b00}, MEM_SIZE=2.
  - RD_WAIT0 captures MEM_DOUT2 into W0 at the end of the cycle.
  - Then DONE. LSU_DONE is high 3 cycles after the accept edge.
- Misaligned load:
  - Same beat for word0, then RD_ISSUE1/RD_WAIT1 for word address +4 (32-bit wrap) into W1.
  - LSU_DONE after 5 cycles.
- Load extraction:
  - merged = {W1,W0} >> (8*ADDR[1:0]).
  - Take the low 8/16/32 bits.
  - Zero-extend if LSU_SIGN=1, else sign-extend.
- MMIO load: single beat with MEM_ADDR2=ADDR unmodified and MEM_SIZE=2. LSU_RDATA=MEM_DOUT2 raw.
- Aligned or MMIO store: one WR_BEAT with MEM_WRITE2=1, MEM_ADDR2=ADDR, MEM_SIZE=LSU_SIZE, MEM_DIN2=WDATA. Then DONE, 2 cycles after accept.
- Misaligned store: N=2 (half) or 4 (word) WR_BEATs. Beat k drives MEM_ADDR2=ADDR+k, MEM_SIZE=0, MEM_DIN2[7:0]=WDATA[8k+:8], with the upper bits 0. Then DONE.
- DONE always lasts one cycle and returns to IDLE. LSU_READY=0 during DONE, so there is no back-to-back accept.
- LSU_RDATA holds its value until the next load completes. It is 0 for stores and errors.

Optional Feature:
- Macro: OTTER_LSU_MISALIGN_SPLIT_EN.
- Defined: misaligned accesses are split as above.
- Undefined: misaligned requests go IDLE -> DONE with LSU_ERR=1 and issue no memory beat. The RD_ISSUE1/RD_WAIT1 states and the byte-beat counter are not built.

Decomposition:
- Package otter_lsu_pkg contains:
  - enum lsu_state_t
  - size constants SZ_BYTE=2'd0, SZ_HALF=2'd1, SZ_WORD=2'd2
  - IO_BASE default
  - function is_misaligned(addr, size)
- One sub-module, otter_lsu_rdalign: combinational merge/shift/extend of W0, W1, offset, size and sign into LSU_RDATA.

Test Plan:
- Load word at 0x100, memory word=0xDEADBEEF -> one READ2 beat at 0x100 with size 2; LSU_DONE at +3 cycles; LSU_RDATA=0xDEADBEEF, LSU_ERR=0.
- Signed byte load at 0x203 of word 0x80112233 -> LSU_RDATA=0xFFFFFF80. The same load with LSU_SIGN=1 -> 0x00000080.
- Word load at 0x102 with words 0x44332211 at 0x100 and 0x88776655 at 0x104 -> READ2 beats at 0x100 then 0x104; LSU_RDATA=0x66554433; LSU_DONE at +5.
- Word store 0xA1B2C3D4 to 0x101 -> four WRITE2 beats, size 0, at 0x101..0x104 with DIN[7:0]=D4, C3, B2, A1; a readback at 0x101 returns 0xA1B2C3D4.
- LSU_SIZE=3 -> no MEM strobes; LSU_DONE=1 with LSU_ERR=1 one cycle after accept. With the macro undefined, a word load at 0x102 behaves the same way.
- RST asserted during RD_WAIT0 of a misaligned load -> next cycle IDLE, LSU_READY=1, all MEM strobes 0, no LSU_DONE.
- MMIO load at 0x11000007 -> a single beat at the unmodified address, no split, no error.
